// File: rtl/ram_arbiter_if.sv
// Requester-side REQ/ACK bus used by the CPU data port and the loader port of ram_arbiter.
interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin CPU/loader arbiter that turns REQ/ACK into the RAM_DC/RAM_WB strobe sequence.
// Define ADDR_CHECK_EN to decode unmapped addresses (skip strobes, return 0, pulse ERR).
module ram_arbiter #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned IO_ADDR   = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    ram_arbiter_if.slave cpu,
    ram_arbiter_if.slave ld,
    output logic [15:0]  RAM_ADDR,
    output logic [15:0]  RAM_IN,
    output logic         RAM_WEN,
    output logic         RAM_DC,
    output logic         RAM_WB,
    input  logic [15:0]  RAM_OUT,
    output logic         BUSY,
    output logic         ERR
);

    typedef enum logic [2:0] {IDLE, SETUP, STB_DC, STB_WB, RESP} state_e;
    typedef enum logic {OWNER_CPU = 1'b0, OWNER_LD = 1'b1} owner_e;

`ifdef ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    owner_e      last_q, last_d, grant;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_in_q, ram_in_d;
    logic        ram_wen_q, ram_wen_d;
    logic        ram_dc_q, ram_dc_d;
    logic        ram_wb_q, ram_wb_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ld_rdata_q, ld_rdata_d;
    logic        unmapped;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant       = last_q;
        ram_addr_d  = ram_addr_q;
        ram_in_d    = ram_in_q;
        ram_wen_d   = ram_wen_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        unmapped    = CHECK_EN && !((32'(ram_addr_q) < RAM_WORDS) || (32'(ram_addr_q) == IO_ADDR));

        case (state_q)
            IDLE: begin
                if (cpu.req || ld.req) begin
                    // Round-robin: on a tie the requester that was not served last wins.
                    grant      = (cpu.req && (!ld.req || last_q == OWNER_LD)) ? OWNER_CPU : OWNER_LD;
                    last_d     = grant;
                    ram_addr_d = (grant == OWNER_CPU) ? cpu.addr  : ld.addr;
                    ram_in_d   = (grant == OWNER_CPU) ? cpu.wdata : ld.wdata;
                    ram_wen_d  = (grant == OWNER_CPU) ? cpu.we    : ld.we;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (unmapped) begin
                    state_d = RESP;
                    if (!ram_wen_q) begin
                        if (last_q == OWNER_CPU) cpu_rdata_d = '0;
                        else                     ld_rdata_d  = '0;
                    end
                end else begin
                    state_d = STB_DC;
                end
            end
            STB_DC: begin
                state_d = ram_wen_q ? STB_WB : RESP;
                if (!ram_wen_q) begin
                    if (last_q == OWNER_CPU) cpu_rdata_d = RAM_OUT;
                    else                     ld_rdata_d  = RAM_OUT;
                end
            end
            STB_WB:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and flags are decoded from the next state so they come straight from flops.
        ram_dc_d  = (state_d == STB_DC);
        ram_wb_d  = (state_d == STB_WB);
        busy_d    = (state_d != IDLE);
        cpu_ack_d = (state_d == RESP) && (last_q == OWNER_CPU);
        ld_ack_d  = (state_d == RESP) && (last_q == OWNER_LD);
        err_d     = (state_d == RESP) && unmapped;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            last_q      <= OWNER_LD;
            ram_addr_q  <= '0;
            ram_in_q    <= '0;
            ram_wen_q   <= 1'b0;
            ram_dc_q    <= 1'b0;
            ram_wb_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ram_addr_q  <= ram_addr_d;
            ram_in_q    <= ram_in_d;
            ram_wen_q   <= ram_wen_d;
            ram_dc_q    <= ram_dc_d;
            ram_wb_q    <= ram_wb_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign RAM_ADDR  = ram_addr_q;
    assign RAM_IN    = ram_in_q;
    assign RAM_WEN   = ram_wen_q;
    assign RAM_DC    = ram_dc_q;
    assign RAM_WB    = ram_wb_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign ld.ack    = ld_ack_q;
    assign ld.rdata  = ld_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural strobe-clocked RAM with IO64/IO65 and
// hand-computed expectations for timing, arbitration, I/O, unmapped access and reset abort.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ram_addr, ram_in;
    logic        ram_wen, ram_dc, ram_wb, busy, err;

    ram_arbiter_if cpu_bus ();
    ram_arbiter_if ld_bus ();

    // RAM model: RAM_DC edge latches address and reads, RAM_WB edge writes the latched address.
    logic [15:0] mem [0:63] = '{default: 16'h0000};
    logic [15:0] ram_out   = 16'h0000;
    logic [15:0] lat_addr  = 16'h0000;
    logic [15:0] io64_out  = 16'h0000;
    logic [15:0] io65_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_ld;
        int          cyc;
        logic [15:0] rdata;
    } ev_t;
    ev_t evq[$];

    ram_arbiter dut (
        .CLK      (clk),
        .RESET    (rst),
        .cpu      (cpu_bus),
        .ld       (ld_bus),
        .RAM_ADDR (ram_addr),
        .RAM_IN   (ram_in),
        .RAM_WEN  (ram_wen),
        .RAM_DC   (ram_dc),
        .RAM_WB   (ram_wb),
        .RAM_OUT  (ram_out),
        .BUSY     (busy),
        .ERR      (err)
    );

    always #5 clk = ~clk;

    always @(posedge ram_dc) begin
        lat_addr <= ram_addr;
        if (ram_addr < 16'd64)       ram_out <= mem[ram_addr[5:0]];
        else if (ram_addr == 16'd64) ram_out <= io65_in;
    end

    always @(posedge ram_wb) begin
        if (ram_wen) begin
            if (lat_addr < 16'd64)       mem[lat_addr[5:0]] <= ram_in;
            else if (lat_addr == 16'd64) io64_out <= ram_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit is_ld, input bit req, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (is_ld) begin
            ld_bus.req = req; ld_bus.we = we; ld_bus.addr = addr; ld_bus.wdata = wdata;
        end else begin
            cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = addr; cpu_bus.wdata = wdata;
        end
    endtask

    // Starts in an IDLE-cycle negedge, returns at the IDLE-cycle negedge after the ACK.
    task automatic do_txn(input string tag, input bit is_ld, input bit we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output int ack_cyc, output int dc_cyc, output int wb_cyc,
                          output logic err_seen, output logic [15:0] rdata);
        logic overlap, other_ack, ack;
        ack_cyc = 0; dc_cyc = 0; wb_cyc = 0; err_seen = 1'b0; rdata = 16'h0;
        overlap = 1'b0; other_ack = 1'b0;
        drive(is_ld, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ram_dc && dc_cyc == 0) dc_cyc = c;
            if (ram_wb && wb_cyc == 0) wb_cyc = c;
            if (ram_dc && ram_wb) overlap = 1'b1;
            ack = is_ld ? ld_bus.ack : cpu_bus.ack;
            if (is_ld ? cpu_bus.ack : ld_bus.ack) other_ack = 1'b1;
            if (ack) begin
                ack_cyc  = c;
                err_seen = err;
                rdata    = is_ld ? ld_bus.rdata : cpu_bus.rdata;
                break;
            end
        end
        drive(is_ld, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        check({tag, "_strobe_overlap"}, 32'(overlap), 0);
        check({tag, "_other_ack"}, 32'(other_ack), 0);
    endtask

    task automatic record(input int c);
        if (cpu_bus.ack) evq.push_back('{1'b0, c, cpu_bus.rdata});
        if (ld_bus.ack)  evq.push_back('{1'b1, c, ld_bus.rdata});
    endtask

    task automatic check_ev(input string tag, input int idx, input bit is_ld,
                            input int cyc, input logic [15:0] rd);
        ev_t e;
        if (idx < evq.size()) e = evq[idx];
        else                  e = '{1'b0, -1, 16'hxxxx};
        check({tag, "_who"}, 32'(e.is_ld), 32'(is_ld));
        check({tag, "_cyc"}, e.cyc, cyc);
        check({tag, "_rdata"}, 32'(e.rdata), 32'(rd));
    endtask

    initial begin
        int          ack_c, dc_c, wb_c;
        logic        err_s;
        logic [15:0] rd;

        rst = 1'b1;
        io65_in = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); tick();

        check("rst_busy", 32'(busy), 0);
        check("rst_dc", 32'(ram_dc), 0);
        check("rst_wb", 32'(ram_wb), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_cpu_ack", 32'(cpu_bus.ack), 0);
        check("rst_ld_ack", 32'(ld_bus.ack), 0);
        check("rst_cpu_rdata", 32'(cpu_bus.rdata), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        tick();

        // CPU write then read-back of address 5.
        do_txn("wr5", 1'b0, 1'b1, 16'd5, 16'h1234, ack_c, dc_c, wb_c, err_s, rd);
        check("wr5_dc_cyc", dc_c, 2);
        check("wr5_wb_cyc", wb_c, 3);
        check("wr5_ack_cyc", ack_c, 4);
        check("wr5_mem", 32'(mem[5]), 32'h1234);
        check("wr5_addr_hold", 32'(ram_addr), 5);
        check("wr5_idle", 32'(busy), 0);
        do_txn("rd5", 1'b0, 1'b0, 16'd5, 16'h0, ack_c, dc_c, wb_c, err_s, rd);
        check("rd5_dc_cyc", dc_c, 2);
        check("rd5_wb_cyc", wb_c, 0);
        check("rd5_ack_cyc", ack_c, 3);
        check("rd5_rdata", 32'(rd), 32'h1234);

        // Preload words used later.
        do_txn("wr1", 1'b0, 1'b1, 16'd1, 16'h1111, ack_c, dc_c, wb_c, err_s, rd);
        do_txn("wr2", 1'b1, 1'b1, 16'd2, 16'h2222, ack_c, dc_c, wb_c, err_s, rd);
        do_txn("wr7", 1'b0, 1'b1, 16'd7, 16'h7777, ack_c, dc_c, wb_c, err_s, rd);
        check("wr2_ld_ack_cyc", ack_c, 4);
        check("wr7_mem", 32'(mem[7]), 32'h7777);

        // Simultaneous held requests after reset: CPU, LD, CPU, LD.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        evq.delete();
        drive(1'b0, 1'b1, 1'b0, 16'd1, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'd2, 16'h0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            record(c);
            if (c == 15) begin
                drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            end
        end
        check("rr_events", evq.size(), 4);
        check_ev("rr0", 0, 1'b0, 3, 16'h1111);
        check_ev("rr1", 1, 1'b1, 7, 16'h2222);
        check_ev("rr2", 2, 1'b0, 11, 16'h1111);
        check_ev("rr3", 3, 1'b1, 15, 16'h2222);

        // Memory-mapped I/O through the loader port.
        do_txn("io_wr", 1'b1, 1'b1, 16'd64, 16'h00AA, ack_c, dc_c, wb_c, err_s, rd);
        check("io64_out", 32'(io64_out), 32'h00AA);
        io65_in = 16'h5555;
        do_txn("io_rd", 1'b1, 1'b0, 16'd64, 16'h0, ack_c, dc_c, wb_c, err_s, rd);
        check("io65_rdata", 32'(rd), 32'h5555);
        check("io_rd_ack_cyc", ack_c, 3);
        check("cpu_rdata_untouched", 32'(cpu_bus.rdata), 32'h1111);

        // Unmapped read of address 100 after RAM_OUT was left at 0x1234.
        do_txn("pre100", 1'b0, 1'b0, 16'd5, 16'h0, ack_c, dc_c, wb_c, err_s, rd);
        check("pre100_rdata", 32'(rd), 32'h1234);
        do_txn("rd100", 1'b0, 1'b0, 16'd100, 16'h0, ack_c, dc_c, wb_c, err_s, rd);
`ifdef ADDR_CHECK_EN
        check("rd100_ack_cyc", ack_c, 2);
        check("rd100_dc_cyc", dc_c, 0);
        check("rd100_rdata", 32'(rd), 0);
        check("rd100_err", 32'(err_s), 1);
`else
        check("rd100_ack_cyc", ack_c, 3);
        check("rd100_dc_cyc", dc_c, 2);
        check("rd100_rdata", 32'(rd), 32'h1234);
        check("rd100_err", 32'(err_s), 0);
`endif
        check("rd100_err_cleared", 32'(err), 0);

        // Reset during STB_DC of a write: the write must be dropped.
        drive(1'b0, 1'b1, 1'b1, 16'd7, 16'hBEEF);
        tick(); tick();
        check("abort_in_dc", 32'(ram_dc), 1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_dc", 32'(ram_dc), 0);
        check("abort_wb", 32'(ram_wb), 0);
        check("abort_ack", 32'(cpu_bus.ack), 0);
        rst = 1'b0;
        tick();
        check("abort_wb_late", 32'(ram_wb), 0);
        check("abort_mem", 32'(mem[7]), 32'h7777);
        do_txn("rd7", 1'b0, 1'b0, 16'd7, 16'h0, ack_c, dc_c, wb_c, err_s, rd);
        check("rd7_rdata", 32'(rd), 32'h7777);

        // CPU streams reads; LD raises REQ mid-transaction and is served at the next IDLE.
        evq.delete();
        drive(1'b0, 1'b1, 1'b0, 16'd1, 16'h0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            record(c);
            if (ld_bus.ack) drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            if (c == 9)     drive(1'b1, 1'b1, 1'b0, 16'd2, 16'h0);
            if (c == 19)    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        check("stream_events", evq.size(), 5);
        check_ev("st0", 0, 1'b0, 3, 16'h1111);
        check_ev("st1", 1, 1'b0, 7, 16'h1111);
        check_ev("st2", 2, 1'b0, 11, 16'h1111);
        check_ev("st3", 3, 1'b1, 15, 16'h2222);
        check_ev("st4", 4, 1'b0, 19, 16'h1111);
        check("stream_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
